// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame controller: FSM state encoding and
// default sizing of the frame, buffer address and receive timeout.
package uart_frame_pkg;

  localparam int FRAME_BYTES_DEF = 64;
  localparam int ADDR_W_DEF      = 6;
  localparam int RX_TIMEOUT_DEF  = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_READ,
    S_LATCH,
    S_TX,
    S_TXHOLD,
    S_TXWAIT
  } state_t;

endpackage

// File: rtl/rx_timeout_cnt.sv
// Idle-cycle counter for the receive side. It counts enabled cycles since the
// last clear and flags the cycle in which the limit is reached. A clear in that
// same cycle wins, so a byte arriving exactly at expiry never raises an error.
module rx_timeout_cnt
  import uart_frame_pkg::*;
#(
  parameter int LIMIT = RX_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Count idle cycles, saturating at the limit until the next clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = enable && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller between a UART and an image processing core: collects one
// frame of received bytes into the input buffer, starts processing, then
// streams the result buffer back out through the UART transmitter byte by byte.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int RX_TIMEOUT  = RX_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              proc_start,
  input  logic              proc_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              frame_err
);

  // One extra bit so a frame filling the whole address space still ends cleanly.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BYTES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] index_reg;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] index_inc;
  logic             timeout_clear;
  logic             timeout_enable;
  logic             timeout_expired;

  assign count_inc = count_reg + 1'b1;
  assign index_inc = index_reg + 1'b1;

  // The idle counter only runs while a frame is being loaded.
  assign timeout_enable = (state_reg == S_LOAD);
  assign timeout_clear  = rx_valid || (state_reg != S_LOAD);

  rx_timeout_cnt #(
    .LIMIT (RX_TIMEOUT)
  ) u_rx_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (timeout_clear),
    .enable  (timeout_enable),
    .expired (timeout_expired)
  );

  assign busy = (state_reg != S_IDLE);

  // Frame sequencing FSM; every strobe defaults low and is raised for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      index_reg  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      proc_start <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      proc_start <= 1'b0;
      rd_en      <= 1'b0;
      tx_start   <= 1'b0;
      frame_err  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (rx_valid) begin
            wr_en     <= 1'b1;
            wr_addr   <= '0;
            wr_data   <= rx_data;
            count_reg <= CNT_W'(1);
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The full check runs in the cycle the last write is on the bus,
          // so proc_start lands exactly one cycle after it.
          if (count_reg == FRAME_FULL) begin
            proc_start <= 1'b1;
            count_reg  <= '0;
            state_reg  <= S_PROC;
          end else if (rx_valid) begin
            wr_en     <= 1'b1;
            wr_addr   <= count_reg[ADDR_W-1:0];
            wr_data   <= rx_data;
            count_reg <= count_inc;
          end else if (timeout_expired) begin
            frame_err <= 1'b1;
            count_reg <= '0;
            state_reg <= S_IDLE;
          end
        end
        S_PROC: begin
          if (proc_done) begin
            index_reg <= '0;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            state_reg <= S_READ;
          end
        end
        S_READ: begin
          state_reg <= S_LATCH;
        end
        S_LATCH: begin
          tx_data   <= rd_data;
          state_reg <= S_TX;
        end
        S_TX: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            state_reg <= S_TXHOLD;
          end
        end
        S_TXHOLD: begin
          // Gives the transmitter a cycle to raise tx_busy after the start pulse.
          state_reg <= S_TXWAIT;
        end
        S_TXWAIT: begin
          if (!tx_busy) begin
            if (index_reg == FRAME_LAST) begin
              state_reg <= S_IDLE;
            end else begin
              index_reg <= index_inc;
              rd_en     <= 1'b1;
              rd_addr   <= index_inc[ADDR_W-1:0];
              state_reg <= S_READ;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: drives frames over rx, models the result
// buffer (data = address + 0x80) and a UART transmitter, and checks the logs.
module tb_uart_frame_ctrl;

  localparam int FB = 64;
  localparam int AW = 6;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          proc_start;
  logic          proc_done = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic          busy;
  logic          frame_err;

  uart_frame_ctrl #(
    .FRAME_BYTES (FB),
    .ADDR_W      (AW),
    .RX_TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .proc_start (proc_start),
    .proc_done  (proc_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  logic [7:0]    tx_q[$];
  int            tx_cyc_q[$];
  int            n_proc = 0;
  int            n_err = 0;
  int            n_rd = 0;
  int            tx_while_busy = 0;
  int            last_wr_cyc = 0;
  int            proc_cyc = 0;
  int            err_cyc = 0;
  int            busy_left = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result buffer: one cycle read latency, contents = address + 0x80.
  always @(posedge clk) if (rd_en) rd_data <= 8'(rd_addr) + 8'h80;

  // Output monitor plus transmitter model (busy 200 cycles after the first
  // byte of a frame, 4 cycles otherwise).
  always @(negedge clk) begin
    if (wr_en) begin
      wr_addr_q.push_back(wr_addr);
      wr_data_q.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (proc_start) begin
      n_proc++;
      proc_cyc = cyc;
    end
    if (frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (rd_en) n_rd++;
    if (tx_start) begin
      if (tx_busy) tx_while_busy++;
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
      tx_busy = 1'b1;
      busy_left = (tx_q.size() == 1) ? 200 : 4;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    tx_cyc_q.delete();
    n_proc = 0;
    n_err = 0;
    n_rd = 0;
    tx_while_busy = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_proc_done();
    @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 64'({wr_en, wr_addr, wr_data, proc_start, rd_en, rd_addr,
                       tx_start, tx_data, busy, frame_err}), 64'd0);
  endtask

  initial begin
    int waited;

    // Reset state.
    idle_cycles(3);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    idle_cycles(2);

    // proc_done while idle is ignored.
    pulse_proc_done();
    idle_cycles(4);
    check_eq("procdone_idle_busy", 64'(busy), 64'd0);
    check_eq("procdone_idle_rd", 64'(n_rd), 64'd0);

    // Frame 1: bytes 0x01..0x40.
    clear_logs();
    for (int i = 0; i < FB; i++) send_byte(8'(i + 1));
    idle_cycles(3);
    check_eq("f1_wr_count", 64'(wr_addr_q.size()), 64'(FB));
    for (int i = 0; i < FB && i < wr_addr_q.size(); i++) begin
      check_eq($sformatf("f1_wr_addr[%0d]", i), 64'(wr_addr_q[i]), 64'(i));
      check_eq($sformatf("f1_wr_data[%0d]", i), 64'(wr_data_q[i]), 64'(i + 1));
    end
    check_eq("f1_proc_start_count", 64'(n_proc), 64'd1);
    check_eq("f1_proc_start_lag", 64'(proc_cyc - last_wr_cyc), 64'd1);
    check_eq("f1_busy_in_proc", 64'(busy), 64'd1);

    // rx traffic during PROC is ignored.
    send_byte(8'hA5);
    send_byte(8'h5A);
    idle_cycles(3);
    check_eq("proc_rx_ignored_wr", 64'(wr_addr_q.size()), 64'(FB));
    check_eq("proc_rx_ignored_err", 64'(n_err), 64'd0);

    // Transmit phase with rx pulses injected along the way.
    pulse_proc_done();
    waited = 0;
    while (busy && waited < 30000) begin
      @(negedge clk);
      waited++;
      rx_valid = ((waited % 97) == 50);
      rx_data  = 8'hEE;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check_eq("f1_tx_done_in_time", 64'(busy), 64'd0);
    check_eq("f1_tx_count", 64'(tx_q.size()), 64'(FB));
    for (int i = 0; i < FB && i < tx_q.size(); i++)
      check_eq($sformatf("f1_tx_data[%0d]", i), 64'(tx_q[i]), 64'(8'h80 + i));
    check_eq("f1_tx_start_while_busy", 64'(tx_while_busy), 64'd0);
    check_eq("f1_rd_count", 64'(n_rd), 64'(FB));
    check_eq("tx_rx_ignored_wr", 64'(wr_addr_q.size()), 64'(FB));
    check_eq("tx_rx_ignored_err", 64'(n_err), 64'd0);
    if (tx_cyc_q.size() >= 3) begin
      check_eq("tx_gap_after_long_busy", 64'(tx_cyc_q[1] - tx_cyc_q[0]), 64'd204);
      check_eq("tx_gap_short_busy", 64'(tx_cyc_q[2] - tx_cyc_q[1]), 64'd8);
    end else begin
      check_eq("tx_gap_samples", 64'(tx_cyc_q.size()), 64'd3);
    end
    $display("frame 1: %0d writes, %0d tx bytes, %0d cycles in tx phase",
             wr_addr_q.size(), tx_q.size(), waited);

    // Frame 2: byte exactly at timeout expiry is accepted, then silence errors out.
    clear_logs();
    send_byte(8'h11);
    idle_cycles(TO - 2);
    send_byte(8'h22);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i));
    idle_cycles(TO + 10);
    check_eq("f2_wr_count", 64'(wr_addr_q.size()), 64'd10);
    if (wr_addr_q.size() >= 2) begin
      check_eq("f2_edge_byte_addr", 64'(wr_addr_q[1]), 64'd1);
      check_eq("f2_edge_byte_data", 64'(wr_data_q[1]), 64'h22);
    end
    check_eq("f2_frame_err_count", 64'(n_err), 64'd1);
    check_eq("f2_frame_err_lag", 64'(err_cyc - last_wr_cyc), 64'(TO));
    check_eq("f2_no_proc_start", 64'(n_proc), 64'd0);
    check_eq("f2_idle_after_err", 64'(busy), 64'd0);
    $display("frame 2: %0d writes, %0d frame errors", wr_addr_q.size(), n_err);

    // Frame 3: full frame after the error lands at 0..63; reset during tx byte 30.
    clear_logs();
    for (int i = 0; i < FB; i++) send_byte(8'(8'hC0 ^ i));
    idle_cycles(3);
    check_eq("f3_wr_count", 64'(wr_addr_q.size()), 64'(FB));
    for (int i = 0; i < FB && i < wr_addr_q.size(); i++) begin
      check_eq($sformatf("f3_wr_addr[%0d]", i), 64'(wr_addr_q[i]), 64'(i));
      check_eq($sformatf("f3_wr_data[%0d]", i), 64'(wr_data_q[i]), 64'(8'hC0 ^ i));
    end
    check_eq("f3_proc_start_count", 64'(n_proc), 64'd1);
    pulse_proc_done();
    waited = 0;
    while (tx_q.size() < 30 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("f3_reach_tx30", 64'(tx_q.size()), 64'd30);
    idle_cycles(2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("f3_async_reset_outputs");
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(400);
    check_eq("f3_no_tx_after_reset", 64'(tx_q.size()), 64'd30);
    check_eq("f3_idle_after_reset", 64'(busy), 64'd0);
    $display("frame 3: %0d writes, reset after %0d tx bytes", wr_addr_q.size(), tx_q.size());

    // Frame 4: reset mid-load discards the partial frame.
    clear_logs();
    for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h70));
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);
    clear_logs();
    send_byte(8'h5A);
    idle_cycles(2);
    check_eq("f4_wr_count", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() >= 1) begin
      check_eq("f4_restart_addr", 64'(wr_addr_q[0]), 64'd0);
      check_eq("f4_restart_data", 64'(wr_data_q[0]), 64'h5A);
    end
    check_eq("f4_loading_busy", 64'(busy), 64'd1);
    $display("frame 4: restarted after reset with %0d write", wr_addr_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter FRAME_BYTES, default 64, number of pixel bytes per image frame (8x8 test image).
REQ-002 Parameter ADDR_W, default 6, buffer address width; FRAME_BYTES SHALL be at most 2**ADDR_W.
REQ-003 Parameter RX_TIMEOUT, default 4096, idle cycles allowed between received bytes mid-frame.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 rx_valid  input  1  one-cycle pulse: uart receiver has a new byte.
REQ-008 rx_data  input  8  received byte, valid with rx_valid.
REQ-009 wr_en / wr_addr / wr_data  output  1 / ADDR_W / 8  write port into input image buffer.
REQ-010 proc_start  output  1  one-cycle pulse: start image processing.
REQ-011 proc_done  input  1  one-cycle pulse: processing finished, result buffer valid.
REQ-012 rd_en / rd_addr  output  1 / ADDR_W  read port of result buffer; rd_data input 8, valid exactly one cycle after rd_en.
REQ-013 tx_start / tx_data  output  1 / 8  one-cycle start pulse and byte for uart transmitter.
REQ-014 tx_busy  input  1  uart transmitter is sending.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_err  output  1  one-cycle pulse on receive timeout.

Function
REQ-017 The block SHALL be a registered FSM with states IDLE, LOAD, PROC, READ, LATCH, TX, TXHOLD, TXWAIT.
REQ-018 IDLE: rx_valid SHALL move to LOAD and write that byte to address 0; byte count becomes 1.
REQ-019 Every accepted byte SHALL produce wr_en=1 for exactly one cycle, the cycle after rx_valid, with wr_addr=count and wr_data=registered rx_data.
REQ-020 LOAD: when count reaches FRAME_BYTES, FSM SHALL enter PROC and pulse proc_start in the cycle after the last wr_en.
REQ-021 LOAD: an idle counter SHALL clear on each rx_valid; when it reaches RX_TIMEOUT-1, frame_err pulses, count clears, FSM returns to IDLE without proc_start.
REQ-022 rx_valid in PROC, READ, LATCH, TX, TXHOLD, TXWAIT SHALL be ignored: no write, no error.
REQ-023 PROC: proc_done SHALL move to READ with read index 0; proc_done in any other state SHALL be ignored.
REQ-024 READ: rd_en=1, rd_addr=index for one cycle, then LATCH captures rd_data into tx_data register.
REQ-025 TX: when tx_busy=0, tx_start SHALL pulse one cycle with tx_data stable; tx_data SHALL hold until next LATCH.
REQ-026 TXHOLD: one guard cycle ignoring tx_busy; then TXWAIT until tx_busy=0.
REQ-027 TXWAIT exit: if index=FRAME_BYTES-1, go IDLE; else increment index, go READ.
REQ-028 Counters SHALL be ADDR_W+1 bits wide so FRAME_BYTES=2**ADDR_W terminates without wrap ambiguity.
REQ-029 rx_valid coincident with timeout expiry SHALL be accepted as a byte; no frame_err.

Reset
REQ-030 rst=0 SHALL immediately force IDLE and clear count, index, idle counter, tx_data to 0.
REQ-031 During reset all outputs SHALL be 0: wr_en, wr_addr, wr_data, proc_start, rd_en, rd_addr, tx_start, tx_data, busy, frame_err.
REQ-032 Reset mid-frame SHALL discard the partial frame; first rx_valid after release starts at address 0.

Structure
REQ-033 State encoding and default parameter values SHALL live in shared package uart_frame_pkg.
REQ-034 The idle-timeout counter SHALL be a sub-module rx_timeout_cnt (clear, enable, expired pulse).
REQ-035 Buffers, uart_rx, uart_tx and processing core are external; this block contains no memory.

Verification
REQ-036 Send 64 bytes 0x01..0x40 -> 64 wr_en pulses, addr 0..63 with data 0x01..0x40, one proc_start after the 64th write.
REQ-037 proc_done with result buffer = address+0x80 -> 64 tx_start pulses, tx_data 0x80..0xBF in order, each only while tx_busy=0, then busy=0.
REQ-038 Send 10 bytes, then silence RX_TIMEOUT cycles -> one frame_err pulse, IDLE; next full frame lands at addresses 0..63.
REQ-039 rx_valid pulses injected during PROC and TX -> no wr_en, no frame_err, tx sequence unchanged.
REQ-040 rst low during byte 30 of TX phase -> all outputs 0 same cycle, no further tx_start after release.
REQ-041 tx_busy held high 200 cycles after one tx_start -> no second tx_start until tx_busy falls.
